// File: rtl/rv32_pkg.sv
// Shared RV32 fetch definitions: machine widths, default boot address and fetch FSM states.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: redirect target, sequential PC+4 (wraps mod 2^32) or hold.
// Latency: purely combinational.
// Backpressure: none; the caller folds stall into advance.
module pc_next_sel
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] branch_address,
    input  logic            redirect,
    input  logic            advance,
    output logic [XLEN-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = branch_address;
        end else if (advance) begin
            pc_next = pc + PC_STEP;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch: issues one imem read per instruction and holds the result for the consumer.
// Latency: ack edge -> instr_valid next cycle; best case one instruction every 2 cycles.
// Backpressure: stall freezes the held instruction; redirects override stall and in-flight reads.
module pc_fetch
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_address,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            misaligned
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic            req_q;
    logic            valid_q;
    logic [ILEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            misaligned_q;

    logic live;
    logic redirect_ok;
    logic redirect_bad;
    logic advance;

    // A faulted block ignores every redirect until reset.
    assign live         = (state_q != ST_FAULT);
    assign redirect_ok  = live && branch_taken && is_word_aligned(branch_address);
    assign redirect_bad = live && branch_taken && !is_word_aligned(branch_address);
    assign advance      = (state_q == ST_HOLD) && !stall;

    pc_next_sel u_pc_next_sel (
        .pc             (pc_q),
        .branch_address (branch_address),
        .redirect       (redirect_ok),
        .advance        (advance),
        .pc_next        (pc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            instr_pc_q   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if (redirect_bad) begin
                state_q      <= ST_FAULT;
                instr_pc_q   <= branch_address;
                misaligned_q <= 1'b1;
                req_q        <= 1'b0;
                valid_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_FETCH: begin
                        if (redirect_ok) begin
                            // An unacked read is abandoned by dropping req for one cycle.
                            req_q <= !(req_q && !imem_ack);
                        end else if (req_q && imem_ack) begin
                            instr_q    <= imem_rdata;
                            instr_pc_q <= pc_q;
                            valid_q    <= 1'b1;
                            req_q      <= 1'b0;
                            state_q    <= ST_HOLD;
                        end else begin
                            req_q <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (redirect_ok || !stall) begin
                            valid_q <= 1'b0;
                            req_q   <= 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end
                    ST_FAULT: begin
                        req_q   <= 1'b0;
                        valid_q <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_FAULT;
                        req_q   <= 1'b0;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch; imem returns addr ^ KEY so every fetched word is predictable.
module tb_pc_fetch;

    localparam logic [31:0] KEY = 32'h5A5A_A5A5;

    logic        clk;
    logic        rst_n;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .misaligned     (misaligned)
    );

    assign imem_rdata = imem_addr ^ KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " req"},   {31'd0, imem_req},    32'd0);
        chk({tag, " valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, " instr"}, instr,                32'd0);
        chk({tag, " ipc"},   instr_pc,             32'd0);
        chk({tag, " mis"},   {31'd0, misaligned},  32'd0);
    endtask

    initial begin
        rst_n = 1'b1; branch_taken = 1'b0; branch_address = '0; stall = 1'b0; imem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outs("reset");
        chk("reset addr", imem_addr, 32'h0);
        tick(); tick();
        chk("in reset req", {31'd0, imem_req}, 32'd0);

        // Sequential fetch with ack always high.
        rst_n = 1'b1; imem_ack = 1'b1;
        tick();
        chk("seq0 req", {31'd0, imem_req}, 32'd1);
        chk("seq0 addr", imem_addr, 32'h0);
        tick();
        chk("seq0 valid", {31'd0, instr_valid}, 32'd1);
        chk("seq0 ipc", instr_pc, 32'h0);
        chk("seq0 instr", instr, KEY);
        chk("seq0 hold req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("seq1 addr", imem_addr, 32'h4);
        chk("seq1 valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("seq1 ipc", instr_pc, 32'h4);
        tick();
        chk("seq2 addr", imem_addr, 32'h8);
        tick();
        chk("seq2 ipc", instr_pc, 32'h8);

        // Stall for three cycles in HOLD.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall valid", {31'd0, instr_valid}, 32'd1);
            chk("stall ipc", instr_pc, 32'h8);
            chk("stall instr", instr, 32'h8 ^ KEY);
            chk("stall req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("post stall addr", imem_addr, 32'hC);
        chk("post stall req", {31'd0, imem_req}, 32'd1);

        // Redirect coincident with ack: data dropped, refetch at target.
        branch_taken = 1'b1; branch_address = 32'h100;
        tick();
        branch_taken = 1'b0; imem_ack = 1'b0;
        chk("br+ack valid", {31'd0, instr_valid}, 32'd0);
        chk("br+ack req", {31'd0, imem_req}, 32'd1);
        chk("br+ack addr", imem_addr, 32'h100);
        chk("br+ack ipc kept", instr_pc, 32'h8);
        tick();
        chk("no ack addr stable", imem_addr, 32'h100);
        chk("no ack req", {31'd0, imem_req}, 32'd1);

        // Redirect with read outstanding: one idle cycle before new request.
        branch_taken = 1'b1; branch_address = 32'h200;
        tick();
        branch_taken = 1'b0;
        chk("abandon req", {31'd0, imem_req}, 32'd0);
        chk("abandon addr", imem_addr, 32'h200);
        tick();
        chk("reissue req", {31'd0, imem_req}, 32'd1);
        chk("reissue addr", imem_addr, 32'h200);
        imem_ack = 1'b1;
        tick();
        chk("0x200 ipc", instr_pc, 32'h200);
        chk("0x200 instr", instr, 32'h200 ^ KEY);

        // Redirect in HOLD beats stall and squashes the held instruction.
        stall = 1'b1; branch_taken = 1'b1; branch_address = 32'h300; imem_ack = 1'b0;
        tick();
        stall = 1'b0;
        chk("hold br valid", {31'd0, instr_valid}, 32'd0);
        chk("hold br req", {31'd0, imem_req}, 32'd1);
        chk("hold br addr", imem_addr, 32'h300);

        // Wrap from the top of the address space.
        branch_address = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        chk("wrap gap req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1;
        tick();
        chk("wrap ipc", instr_pc, 32'hFFFF_FFFC);
        imem_ack = 1'b0;
        tick();
        chk("wrapped addr", imem_addr, 32'h0);
        chk("wrapped req", {31'd0, imem_req}, 32'd1);

        // Asynchronous reset with a read pending.
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outs("async rst");
        imem_ack = 1'b1;
        tick();
        chk("ack in reset req", {31'd0, imem_req}, 32'd0);
        chk("ack in reset valid", {31'd0, instr_valid}, 32'd0);
        rst_n = 1'b1; imem_ack = 1'b0;
        tick();
        chk("refetch req", {31'd0, imem_req}, 32'd1);
        chk("refetch addr", imem_addr, 32'h0);
        imem_ack = 1'b1;
        tick();
        chk("refetch ipc", instr_pc, 32'h0);
        chk("refetch valid", {31'd0, instr_valid}, 32'd1);

        // Misaligned redirect is sticky until reset.
        branch_taken = 1'b1; branch_address = 32'h102;
        tick();
        chk("mis flag", {31'd0, misaligned}, 32'd1);
        chk("mis ipc", instr_pc, 32'h102);
        chk("mis req", {31'd0, imem_req}, 32'd0);
        chk("mis valid", {31'd0, instr_valid}, 32'd0);
        branch_address = 32'h400;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fault req", {31'd0, imem_req}, 32'd0);
            chk("fault mis", {31'd0, misaligned}, 32'd1);
            chk("fault ipc", instr_pc, 32'h102);
        end
        branch_taken = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("fault clr mis", {31'd0, misaligned}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post fault req", {31'd0, imem_req}, 32'd1);
        chk("post fault addr", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
